// File: rtl/teclado_matricial.sv
// teclado_matricial: 4x4 membrane keypad scanner with press/release debounce and key decode.
// Emits one keypad_pressed strobe per accepted press; key holds its code until the next press.
module teclado_matricial #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic       keypad_pressed,
  output logic [4:0] key,
  output logic       held
);

  // state      | meaning
  // S_SCAN     | drive one column per dwell, sample rows on the last dwell cycle
  // S_DEBOUNCE | latched row must stay low DEBOUNCE_CYC cycles, else resume scan
  // S_PRESS    | single strobe cycle, key and held updated on entry
  // S_HOLD     | column frozen, waiting for the latched row to go high
  // S_RELEASE  | latched row must stay high DEBOUNCE_CYC cycles to finish the key

  localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYC) ? SCAN_DIV : DEBOUNCE_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYC - 1);

  typedef enum logic [2:0] {
    S_SCAN,
    S_DEBOUNCE,
    S_PRESS,
    S_HOLD,
    S_RELEASE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    col_q, col_d;
  logic [1:0]    row_q, row_d;
  logic [4:0]    key_q, key_d;
  logic          held_q, held_d;
  logic [3:0]    sync_q, rs_q;
  logic [1:0]    low_row;
  logic          row_low;

  function automatic logic [4:0] decode(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: return 5'd1;
      4'h1: return 5'd2;
      4'h2: return 5'd3;
      4'h3: return 5'd10;
      4'h4: return 5'd4;
      4'h5: return 5'd5;
      4'h6: return 5'd6;
      4'h7: return 5'd11;
      4'h8: return 5'd7;
      4'h9: return 5'd8;
      4'hA: return 5'd9;
      4'hB: return 5'd12;
      4'hC: return 5'd14;
      4'hD: return 5'd0;
      4'hE: return 5'd15;
      default: return 5'd13;
    endcase
  endfunction

  // Lowest-index low row wins when several rows read low together.
  always_comb begin
    if (!rs_q[0])      low_row = 2'd0;
    else if (!rs_q[1]) low_row = 2'd1;
    else if (!rs_q[2]) low_row = 2'd2;
    else               low_row = 2'd3;
  end

  assign row_low = ~rs_q[row_q];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    row_d   = row_q;
    key_d   = key_q;
    held_d  = held_q;
    case (state_q)
      S_SCAN: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          if (rs_q != 4'hF) begin
            row_d   = low_row;
            state_d = S_DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DEBOUNCE: begin
        if (!row_low) begin
          state_d = S_SCAN;
          col_d   = col_q + 2'd1;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = S_PRESS;
          key_d   = decode(row_q, col_q);
          held_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_PRESS: state_d = S_HOLD;
      S_HOLD: begin
        if (!row_low) begin
          cnt_d   = '0;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (row_low) begin
          cnt_d   = '0;
          state_d = S_HOLD;
        end else if (cnt_q == DEB_LAST) begin
          held_d  = 1'b0;
          col_d   = col_q + 2'd1;
          cnt_d   = '0;
          state_d = S_SCAN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_SCAN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 4'hF;
      rs_q    <= 4'hF;
      state_q <= S_SCAN;
      cnt_q   <= '0;
      col_q   <= 2'd0;
      row_q   <= 2'd0;
      key_q   <= 5'd31;
      held_q  <= 1'b0;
    end else begin
      sync_q  <= row_n;
      rs_q    <= sync_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      key_q   <= key_d;
      held_q  <= held_d;
    end
  end

  assign col_n          = ~(4'b0001 << col_q);
  assign keypad_pressed = (state_q == S_PRESS);
  assign key            = key_q;
  assign held           = held_q;

endmodule

// File: doc/teclado_matricial.md
Name: teclado_matricial

Overview:
Scans a 4x4 membrane keypad, debounces the press and the release, and decodes the key. It sits directly upstream of the game/movement controller. Per debounced press it produces a single-cycle keypad_pressed strobe and a 5-bit key code. Codes 2, 6 and 8 are the fly/jump/crouch commands consumed downstream.

Parameters:
SCAN_DIV, 50000, clk cycles each column is driven before its rows are sampled (1 ms at 50 MHz); minimum 2.
DEBOUNCE_CYC, 1000000, consecutive stable cycles required to accept a press or a release (20 ms at 50 MHz); minimum 1.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
row_n  input  4  keypad rows, active-low (external pull-ups), asynchronous to clk
col_n  output  4  keypad column drive, exactly one bit low at any time
keypad_pressed  output  1  one-cycle strobe per accepted press
key  output  5  decoded key code, valid in the strobe cycle and held until the next press
held  output  1  high from the strobe until the release is debounced

Behaviour:
- Reset (asynchronous, rst_n=0):
  - col_n=4'b1110 (column 0), keypad_pressed=0, key=5'd31 (no key), held=0.
  - State SCAN; all counters 0; synchronizer flops set to 4'b1111.
- row_n passes through a 2-flop synchronizer. All decisions use the synchronized value rs.
- Key map, row r / col c to code:
  - r0: 1, 2, 3, A=10
  - r1: 4, 5, 6, B=11
  - r2: 7, 8, 9, C=12
  - r3: *=14, 0, #=15, D=13
  - Code 31 is reserved for "none".
- State SCAN:
  - A dwell counter runs 0..SCAN_DIV-1 with the current column driven.
  - In the cycle the counter equals SCAN_DIV-1, rs is sampled.
  - If any bit of rs is 0: latch col and the lowest-index low row, clear the counter, go to DEBOUNCE. col_n stays frozen.
  - Otherwise advance the column (3 wraps to 0) and restart the dwell.
- State DEBOUNCE:
  - Counter increments each cycle the latched row bit of rs is 0.
  - If that bit reads 1, return to SCAN and advance to the next column (bounce rejected, no strobe).
  - When the counter reaches DEBOUNCE_CYC-1 with the row still low, go to PRESS.
- State PRESS (exactly one cycle):
  - keypad_pressed=1; key=decoded code, registered so both change on the same edge.
  - held=1 from this cycle onward. Next state HOLD.
- State HOLD:
  - Wait while the latched row bit is 0; col_n stays frozen.
  - When the bit reads 1, clear the counter and go to RELEASE.
- State RELEASE:
  - Counter increments while the latched row bit is 1; any 0 clears the counter and returns to HOLD.
  - At DEBOUNCE_CYC-1: held=0, advance the column, go to SCAN.
- keypad_pressed is 0 in every state except PRESS.
- Auto-repeat is not supported: a key held indefinitely produces exactly one strobe.
- Multiple keys:
  - Only the latched key is tracked until its release is debounced.
  - Other keys pressed meanwhile are ignored. They are detected on a later scan if still down.
- Minimum press-to-strobe latency after the row settles: 2 (synchronizer) + remaining dwell + DEBOUNCE_CYC + 1 cycles.
- Reset asserted mid-debounce, mid-hold or during PRESS: outputs go to reset values immediately and no strobe is emitted after reset.
- The key output is never cleared on release; downstream samples it only when keypad_pressed=1.

Test Plan:
(SCAN_DIV=4, DEBOUNCE_CYC=8 for all benches)
- Reset then idle (rows 4'b1111) for 64 cycles -> col_n cycles 1110, 1101, 1011, 0111, back to 1110, each held 4 cycles; keypad_pressed never 1; key=31.
- Press row0/col1 cleanly, held 40 cycles -> exactly one keypad_pressed pulse with key=2 in that cycle; held=1 until 8 cycles after release; col_n frozen at 1101 throughout.
- Press row1/col2 (key 6) with a 3-cycle glitch, then high, then stable low -> glitch yields no strobe; the stable press yields one strobe with key=6.
- Press row2/col1 (key 8), release with 2-cycle bounce -> one strobe only; held falls 8 stable-high cycles after the last bounce; scanning resumes at column 2.
- Rows 0 and 3 both low on column 1 -> strobe with key=2 (row-0 priority); no second strobe until both keys are released.
- rst_n pulsed low during DEBOUNCE -> col_n=1110, key=31, held=0 asynchronously; no keypad_pressed pulse afterward without a new debounced press.
